// File: rtl/uart_tx.sv
// 8N1 serial transmitter with a small byte FIFO on a valid/ready input.
// Frames are 10*CLKS_PER_BIT cycles; queued bytes go out back-to-back.
module uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [7:0]                    in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_e;

   state_e          state_q,    state_d;
   logic [7:0]      shift_q,    shift_d;
   logic [2:0]      bit_idx_q,  bit_idx_d;
   logic [BW-1:0]   baud_q,     baud_d;
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [7:0]      mem_d [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q,   wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q,   rd_ptr_d;
   logic [CW-1:0]   count_q,    count_d;
   logic            tx_q,       tx_d;
   logic            busy_q,     busy_d;
   logic            in_ready_q, in_ready_d;

   logic            push;
   logic            pop;
   logic            baud_last;

   assign in_ready   = in_ready_q;
   assign tx         = tx_q;
   assign busy       = busy_q;
   assign fifo_count = count_q;

   // Frame sequencer: decides when to pop the FIFO and advances bit timing.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      baud_d    = baud_q;
      pop       = 1'b0;
      baud_last = (baud_q == BAUD_LAST);

      case (state_q)
         S_IDLE: begin
            baud_d = '0;
            if (count_q != '0) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_ptr_q];
               state_d = S_START;
            end
         end
         S_START: begin
            if (baud_last) begin
               baud_d    = '0;
               bit_idx_d = '0;
               state_d   = S_DATA;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         S_DATA: begin
            if (baud_last) begin
               baud_d    = '0;
               shift_d   = {1'b0, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = S_STOP;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         S_STOP: begin
            if (baud_last) begin
               baud_d = '0;
               // Chain straight into the next start bit when more data is queued.
               if (count_q != '0) begin
                  pop     = 1'b1;
                  shift_d = mem_q[rd_ptr_q];
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Byte FIFO; in_ready_q gates the push so a full FIFO never accepts.
   always_comb begin
      push     = in_valid && in_ready_q;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (push) begin
         mem_d[wr_ptr_q] = in_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Outputs are computed from next state so the flops line up with the state.
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
      busy_d     = (state_d != S_IDLE) || (count_d != '0);
      in_ready_d = (count_d != CNT_FULL);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         shift_q    <= '0;
         bit_idx_q  <= '0;
         baud_q     <= '0;
         mem_q      <= '{default: '0};
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_idx_q  <= bit_idx_d;
         baud_q     <= baud_d;
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         in_ready_q <= in_ready_d;
      end
   end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Byte-serial transmitter for the board debug/console link; the transmit-side counterpart of the console receive path.
- Accepts bytes from the core over a valid/ready handshake and buffers them in a small FIFO.
- Shifts each byte out as 8N1 asynchronous serial: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- Sits between the core's memory-mapped I/O decode and the TX pin.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 2..65535.
- FIFO_DEPTH, 4, byte FIFO entries; power of two, legal range 2..16.

Ports:
- clk  in  1  single system clock; everything is sampled on the rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the clk rising edge.
- in_data  in  8  byte to transmit.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  FIFO can accept a byte this cycle.
- tx  out  1  serial line; idles high.
- busy  out  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of bytes currently held in the FIFO.

Behaviour:
- Reset (rst_n low at a clk edge):
  - tx=1, in_ready=1, busy=0, fifo_count=0.
  - FIFO pointers cleared; state=IDLE; bit and baud counters cleared.
  - Reset mid-frame aborts the frame: tx returns to 1 on the next edge and any queued bytes are discarded.
- Handshake:
  - A byte is accepted on a clk edge where in_valid && in_ready.
  - in_ready = (fifo_count != FIFO_DEPTH), a registered-state function with no combinational path from in_valid.
  - Writes while full are ignored; in_valid may stay high until in_ready.
- FIFO:
  - Same-cycle push and pop when full: pop frees a slot but in_ready reflects pre-pop state, so no push occurs.
  - Same-cycle push and pop when non-full: both occur and fifo_count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- State machine IDLE -> START -> DATA -> STOP -> (START | IDLE):
  - IDLE:
    - tx=1.
    - If fifo_count != 0, pop the head byte into the shift register and go to START on the next edge.
    - The first start-bit cycle begins on the edge after the push at the earliest: 1 cycle of latency from acceptance to tx falling.
  - START:
    - tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA:
    - tx = shift[0] for CLKS_PER_BIT cycles per bit, then shift right and increment the index.
    - After bit 7 completes, go to STOP.
  - STOP:
    - tx=1 for CLKS_PER_BIT cycles.
    - At the end of STOP, if the FIFO is non-empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
- Frame length is exactly 10*CLKS_PER_BIT cycles; back-to-back frames are contiguous.
- Baud counter counts 0..CLKS_PER_BIT-1, resets at each bit boundary, and does not free-run in IDLE.
- busy = (state != IDLE) || (fifo_count != 0), registered.
- tx is driven from a flop (glitch-free).

Test Plan:
- Reset with CLKS_PER_BIT=4 -> tx=1, in_ready=1, busy=0, fifo_count=0 on the first edge after rst_n=0.
- Push 8'hA5, CLKS_PER_BIT=4 -> tx sequence (4 cycles each) 0,1,0,1,0,0,1,0,1,1; busy falls 40 cycles after tx falls.
- Hold in_valid high with 5 bytes 01..05 and FIFO_DEPTH=4:
  - The FIFO fills (the first byte is popped immediately, so 5 accepts occur before in_ready drops).
  - All 5 frames go out contiguously: 5*10*CLKS_PER_BIT cycles with no high gap between stop and start.
- Keep the FIFO full and present a 6th byte -> in_ready=0 and the byte is not accepted.
  - A same-cycle pop at STOP end raises in_ready the next cycle.
  - The byte is then accepted and transmitted as-is.
- Assert rst_n=0 during data bit 3 of 8'hFF with 2 bytes queued -> tx=1 next edge, fifo_count=0, no further frames.
- Push 8'h00 then 8'hFF; sample tx mid-bit on a model receiver -> decodes 00, FF; stop bits are high for the full CLKS_PER_BIT cycles.
